// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - radix-2 iterative multiply/divide sequencer owning HI/LO
// Shift-add multiply, restoring divide; sign fixup applied in a single FIX cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
  logic             is_div, neg_q, neg_r, div_zero;
  logic             accept, commit, mt_ok, last;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign last   = (cnt == CW'(WIDTH-1));
  assign mt_ok  = (state == IDLE) && !start;
  assign commit = (state == FIX) && !flush;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start && !flush) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign a_abs = (op_sign && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op_sign && b[WIDTH-1]) ? -b : b;

  // acc_hi is the running partial product / remainder; acc_lo holds the
  // multiplier or dividend bits still to be consumed and collects the result.
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};

  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= commit;
      if (accept) begin
        cnt      <= '0;
        acc_hi   <= '0;
        acc_lo   <= op_div ? a_abs : b_abs;
        opnd     <= op_div ? b_abs : a_abs;
        a_raw    <= a;
        is_div   <= op_div;
        neg_q    <= op_sign && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r    <= op_sign && a[WIDTH-1];
        div_zero <= (b == '0);
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          if (!div_trial[WIDTH]) begin
            acc_hi <= div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end

      if (commit) begin
        if (!is_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
          hi <= a_raw;
          lo <= '1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end else if (mt_ok) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq
// Results are compared against plain-arithmetic HI/LO expectations.
module tb_muldiv_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0, op_div = 1'b0, op_sign = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, wdata = '0;
  logic             flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .op_sign(op_sign),
    .a(a), .b(b), .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input bit dv, input bit sg,
                                         input logic [31:0] oa, input logic [31:0] ob);
    int     sa, sb;
    longint pa, pb;
    logic [31:0] q, r;
    sa = $signed(oa);
    sb = $signed(ob);
    if (!dv) begin
      if (sg) begin
        pa = sa;
        pb = sb;
        return pa * pb;
      end
      return {32'd0, oa} * {32'd0, ob};
    end
    if (ob == 0) return {oa, 32'hFFFF_FFFF};
    if (sg && oa == 32'h8000_0000 && ob == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (sg) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = oa / ob;
      r = oa % ob;
    end
    return {r, q};
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!done && n < 100);
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input bit dv, input bit sg, input logic [31:0] oa, input logic [31:0] ob);
    logic [63:0] e;
    int n;
    e = ref_op(dv, sg, oa, ob);
    op_div = dv; op_sign = sg; a = oa; b = ob; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(n);
    check("latency", n, WIDTH + 1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check($sformatf("result dv=%0d sg=%0d a=%h b=%h", dv, sg, oa, ob), {hi, lo}, e);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] prior;
    logic [63:0] e;
    int n, dones;

    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;

    run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(0, 1, -32'sd3, 32'd7);
    run_op(1, 1, -32'sd7, 32'd2);
    run_op(1, 0, 32'd100, 32'd7);
    run_op(1, 1, 32'h1234_5678, 32'd0);
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);

    // start pulse while busy must be ignored
    e = ref_op(0, 1, -32'sd3, 32'd7);
    op_div = 0; op_sign = 1; a = -32'sd3; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 begin op_div = 1; a = 32'd1; b = 32'd1; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    wait_done(n);
    check("ignored_start_latency", n, WIDTH + 1 - 6);
    check("ignored_start_result", {hi, lo}, e);

    // flush mid-run: no done, hi/lo hold
    prior = {hi, lo};
    op_div = 0; op_sign = 0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hilo", {hi, lo}, prior);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_hilo_later", {hi, lo}, prior);

    // flush and start together in IDLE: start not accepted
    op_div = 0; a = 32'd2; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 begin start = 1'b0; flush = 1'b0; end
    check("flush_beats_start", {63'd0, busy}, 64'd0);

    // mt writes
    wdata = 32'hAAAA_0000; mthi = 1'b1;
    @(posedge clk); #1 mthi = 1'b0;
    check("mthi_idle", {hi, lo}, {32'hAAAA_0000, prior[31:0]});
    wdata = 32'h1357_2468; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1 begin mthi = 1'b0; mtlo = 1'b0; end
    check("mthi_mtlo_both", {hi, lo}, {32'h1357_2468, 32'h1357_2468});

    op_div = 0; op_sign = 0; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 begin start = 1'b0; mtlo = 1'b1; wdata = 32'h0000_1234; end
    repeat (3) @(posedge clk);
    #1 mtlo = 1'b0;
    check("mtlo_busy_dropped", {32'd0, lo}, {32'd0, 32'h1357_2468});
    wait_done(n);
    check("mul_after_mt", {hi, lo}, 64'd6);

    op_div = 1; op_sign = 0; a = 32'd100; b = 32'd7; start = 1'b1; mtlo = 1'b1; wdata = 32'h5555;
    @(posedge clk); #1 begin start = 1'b0; mtlo = 1'b0; end
    check("start_beats_mtlo", {32'd0, lo}, 64'd6);
    wait_done(n);
    check("divu_after_mt", {hi, lo}, {32'd2, 32'd14});

    // async reset mid-run
    op_div = 0; op_sign = 1; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("reset_mid_busy", {63'd0, busy}, 64'd0);
    check("reset_mid_hilo", {hi, lo}, 64'd0);
    check("reset_mid_done", {63'd0, done}, 64'd0);
    @(negedge clk) reset = 1'b0;
    run_op(0, 0, 32'd6, 32'd7);

    // randomized operations, idle gap of zero exercises back-to-back starts
    for (int i = 0; i < 150; i++) begin
      run_op(1'($urandom), 1'($urandom), pick(), pick());
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
